// File: rtl/tile_plane_serializer.sv
// Planar tile-row to per-layer pixel stream serializer with fetch/display row
// buffering, fine X scroll, horizontal flip and sticky underrun detection.

module tsp_lane #(
   parameter int BPP      = 4,
   parameter int TILE_W   = 8,
   parameter int PAL_W    = 8,
   parameter int FLIP_BIT = 0,
   parameter int FLIP_EN  = 1,
   parameter int PW       = $clog2(TILE_W)
) (
   input  logic                    clk_24M,
   input  logic                    nRES,
   input  logic                    pix_ce,
   input  logic                    line_start,
   input  logic                    load,
   input  logic [BPP*TILE_W-1:0]   row,
   input  logic [PAL_W-1:0]        attr,
   input  logic [PW-1:0]           fine,
   output logic [PAL_W+BPP-1:0]    dout,
   output logic                    opaque,
   output logic                    underrun
);
   logic [BPP-1:0][TILE_W-1:0] fet_row, disp_row;
   logic [PAL_W-1:0]           fet_attr, disp_attr;
   logic                       fet_full, disp_vld;
   logic [PW-1:0]              phase, sel, pix_idx;
   logic [BPP-1:0]             color;
   logic                       xfer;

   assign sel     = phase + fine;
   // TILE_W is a power of two, so TILE_W-1-sel is the bitwise complement
   assign pix_idx = ((FLIP_EN != 0) && disp_attr[FLIP_BIT]) ? ~sel : sel;
   assign xfer    = pix_ce && !line_start && (sel == '1);

   for (genvar p = 0; p < BPP; p++) begin : g_plane
      assign color[p] = disp_row[p][pix_idx];
   end

   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         phase     <= '0;
         disp_row  <= '0;
         disp_attr <= '0;
         disp_vld  <= 1'b0;
         dout      <= '0;
         opaque    <= 1'b0;
         underrun  <= 1'b0;
      end else if (line_start) begin
         phase    <= '0;
         disp_vld <= 1'b0;
         dout     <= '0;
         opaque   <= 1'b0;
         underrun <= 1'b0;
      end else if (pix_ce) begin
         phase  <= phase + 1'b1;
         dout   <= {disp_attr, disp_vld ? color : {BPP{1'b0}}};
         opaque <= disp_vld && (color != '0);
         if (xfer) begin
            disp_row  <= fet_row;
            disp_attr <= fet_attr;
            disp_vld  <= fet_full;
            if (!fet_full) underrun <= 1'b1;
         end
      end
   end

   // Fetch side: a load coinciding with a transfer refills the buffer after
   // the old contents have moved to display.
   always_ff @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         fet_row  <= '0;
         fet_attr <= '0;
         fet_full <= 1'b0;
      end else if (load) begin
         fet_row  <= row;
         fet_attr <= attr;
         fet_full <= 1'b1;
      end else if (xfer) begin
         fet_full <= 1'b0;
      end
   end
endmodule

module tile_plane_serializer #(
   parameter int LAYERS   = 3,
   parameter int BPP      = 4,
   parameter int TILE_W   = 8,
   parameter int PAL_W    = 8,
   parameter int FLIP_BIT = 0,
   parameter int FLIP_EN  = 1
) (
   input  logic                                 clk_24M,
   input  logic                                 nRES,
   input  logic                                 pix_ce,
   input  logic                                 line_start,
   input  logic [LAYERS-1:0]                    load,
   input  logic [LAYERS*BPP*TILE_W-1:0]         vc,
   input  logic [LAYERS*PAL_W-1:0]              col,
   input  logic [LAYERS*$clog2(TILE_W)-1:0]     fine,
   output logic [LAYERS*(PAL_W+BPP)-1:0]        dout,
   output logic [LAYERS-1:0]                    opaque,
   output logic [LAYERS-1:0]                    underrun
);
   localparam int PW = $clog2(TILE_W);
   localparam int RW = BPP*TILE_W;
   localparam int DW = PAL_W+BPP;

   for (genvar l = 0; l < LAYERS; l++) begin : g_lane
      tsp_lane #(
         .BPP(BPP), .TILE_W(TILE_W), .PAL_W(PAL_W),
         .FLIP_BIT(FLIP_BIT), .FLIP_EN(FLIP_EN), .PW(PW)
      ) u_lane (
         .clk_24M    (clk_24M),
         .nRES       (nRES),
         .pix_ce     (pix_ce),
         .line_start (line_start),
         .load       (load[l]),
         .row        (vc[l*RW +: RW]),
         .attr       (col[l*PAL_W +: PAL_W]),
         .fine       (fine[l*PW +: PW]),
         .dout       (dout[l*DW +: DW]),
         .opaque     (opaque[l]),
         .underrun   (underrun[l])
      );
   end
endmodule

// File: tb/tb_tile_plane_serializer.sv
// Self-checking bench: pixel-array reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_tile_plane_serializer;
   localparam int LAYERS = 3, BPP = 4, TILE_W = 8, PAL_W = 8, FLIP_BIT = 0, FLIP_EN = 1;
   localparam int PW = 3, RW = BPP*TILE_W, DW = PAL_W+BPP, FW = LAYERS*PW;

   logic                   clk_24M = 0, nRES = 0, pix_ce = 0, line_start = 0;
   logic [LAYERS-1:0]      load = '0;
   logic [LAYERS*RW-1:0]   vc = '0;
   logic [LAYERS*PAL_W-1:0] col = '0;
   logic [FW-1:0]          fine = '0;
   logic [LAYERS*DW-1:0]   dout;
   logic [LAYERS-1:0]      opaque, underrun;

   tile_plane_serializer #(
      .LAYERS(LAYERS), .BPP(BPP), .TILE_W(TILE_W), .PAL_W(PAL_W),
      .FLIP_BIT(FLIP_BIT), .FLIP_EN(FLIP_EN)
   ) dut (
      .clk_24M(clk_24M), .nRES(nRES), .pix_ce(pix_ce), .line_start(line_start),
      .load(load), .vc(vc), .col(col), .fine(fine),
      .dout(dout), .opaque(opaque), .underrun(underrun)
   );

   always #5 clk_24M = ~clk_24M;

   int errs = 0, checks = 0;

   task automatic chk(input string name, input int l, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", name, l, act, exp, $time);
      end
   endtask

   // Reference model: rows held as arrays of pixel colors
   int cnt [LAYERS];
   int fpix[LAYERS][TILE_W], dpix[LAYERS][TILE_W];
   int fattr[LAYERS], dattr[LAYERS];
   bit full[LAYERS], dval[LAYERS];
   int e_dout[LAYERS];
   bit e_op[LAYERS], e_und[LAYERS];
   int ms, mi, mc;

   function automatic int row_pix(input logic [RW-1:0] r, input int i);
      int v = 0;
      for (int p = 0; p < BPP; p++) if (r[p*TILE_W+i]) v |= (1 << p);
      return v;
   endfunction

   always @(posedge clk_24M or negedge nRES) begin
      if (!nRES) begin
         for (int l = 0; l < LAYERS; l++) begin
            cnt[l] = 0; full[l] = 0; dval[l] = 0; fattr[l] = 0; dattr[l] = 0;
            e_dout[l] = 0; e_op[l] = 0; e_und[l] = 0;
            for (int i = 0; i < TILE_W; i++) begin fpix[l][i] = 0; dpix[l][i] = 0; end
         end
      end else begin
         for (int l = 0; l < LAYERS; l++) begin
            ms = (cnt[l] + int'(fine[l*PW +: PW])) % TILE_W;
            if (line_start) begin
               cnt[l] = 0; dval[l] = 0; e_dout[l] = 0; e_op[l] = 0; e_und[l] = 0;
            end else if (pix_ce) begin
               mi = (FLIP_EN != 0 && ((dattr[l] >> FLIP_BIT) & 1) == 1) ? TILE_W-1-ms : ms;
               mc = dval[l] ? dpix[l][mi] : 0;
               e_dout[l] = (dattr[l] << BPP) | mc;
               e_op[l] = (mc != 0);
               cnt[l]++;
               if (ms == TILE_W-1) begin
                  for (int i = 0; i < TILE_W; i++) dpix[l][i] = fpix[l][i];
                  dattr[l] = fattr[l];
                  dval[l] = full[l];
                  if (!full[l]) e_und[l] = 1;
                  full[l] = 0;
               end
            end
            if (load[l]) begin
               for (int i = 0; i < TILE_W; i++) fpix[l][i] = row_pix(vc[l*RW +: RW], i);
               fattr[l] = int'(col[l*PAL_W +: PAL_W]);
               full[l] = 1;
            end
         end
      end
   end

   always @(negedge clk_24M) begin
      for (int l = 0; l < LAYERS; l++) begin
         chk("dout", l, int'(dout[l*DW +: DW]), e_dout[l]);
         chk("opaque", l, int'(opaque[l]), int'(e_op[l]));
         chk("underrun", l, int'(underrun[l]), int'(e_und[l]));
      end
   end

   task automatic tick();
      @(posedge clk_24M); #1;
      pix_ce = 0; line_start = 0; load = '0;
   endtask

   task automatic pce();
      pix_ce = 1; tick(); tick();
   endtask

   task automatic do_load(input int l, input logic [RW-1:0] r, input logic [PAL_W-1:0] a);
      vc[l*RW +: RW] = r; col[l*PAL_W +: PAL_W] = a; load[l] = 1'b1;
   endtask

   // Drive one pix_ce and, once it has taken effect, compare layer 0 literally
   task automatic pce_chk0(input string name, input int color, input int pal);
      pix_ce = 1; tick();
      chk({name, "_color"}, 0, int'(dout[BPP-1:0]), color);
      chk({name, "_pal"}, 0, int'(dout[DW-1:BPP]), pal);
      tick();
   endtask

   int seq_a5[TILE_W] = '{1,0,1,0,0,1,0,1};

   initial begin
      repeat (3) @(posedge clk_24M);
      #1;
      chk("reset_dout", 0, int'(dout), 0);
      chk("reset_und", 0, int'(underrun), 0);
      nRES = 1;

      // Plain row, no scroll
      do_load(0, 32'h0000_00A5, 8'h30); tick();
      line_start = 1; tick();
      repeat (TILE_W) pce();
      for (int k = 0; k < TILE_W; k++) pce_chk0("a5", seq_a5[k], 8'h30);

      // Flipped, symmetric row
      do_load(0, 32'h0000_00A5, 8'h31); tick();
      line_start = 1; tick();
      repeat (TILE_W) pce();
      for (int k = 0; k < TILE_W; k++) pce_chk0("a5flip", seq_a5[TILE_W-1-k], 8'h31);

      // Flipped, pixel 0 only: appears last; nothing queued so boundary underruns
      do_load(0, 32'h0000_0001, 8'h31); tick();
      line_start = 1; tick();
      repeat (TILE_W) pce();
      for (int k = 0; k < TILE_W; k++) pce_chk0("p0flip", (k == TILE_W-1) ? 1 : 0, 8'h31);
      chk("und_set", 0, int'(underrun[0]), 1);
      pce_chk0("und_out", 0, 8'h31);
      chk("und_opaque", 0, int'(opaque[0]), 0);
      chk("und_sticky", 0, int'(underrun[0]), 1);
      line_start = 1; tick();
      chk("und_clear", 0, int'(underrun[0]), 0);

      // Fine scroll 3: transfer on pix_ce 5, pixel 0 on pix_ce 6
      fine[PW-1:0] = 3'd3;
      line_start = 1; tick();
      repeat (4) pce();
      do_load(0, 32'h0000_0001, 8'h22); tick();
      pce();
      chk("fine_und", 0, int'(underrun[0]), 0);
      pce_chk0("fine_p0", 1, 8'h22);
      pce_chk0("fine_p1", 0, 8'h22);
      fine[PW-1:0] = 3'd0;

      // Load coincident with transfer
      do_load(0, 32'h0000_00FF, 8'h40); tick();
      line_start = 1; tick();
      repeat (TILE_W-1) pce();
      do_load(0, 32'h0000_FF00, 8'h50); pce();
      for (int k = 0; k < TILE_W; k++) pce_chk0("old_row", 1, 8'h40);
      chk("coinc_und", 0, int'(underrun[0]), 0);
      pce_chk0("new_row", 2, 8'h50);
      chk("coinc_opaque", 0, int'(opaque[0]), 1);

      // Asynchronous reset mid-line with non-zero output
      do_load(0, 32'h0000_00FF, 8'h40); tick();
      nRES = 0; #1;
      chk("areset_dout", 0, int'(dout), 0);
      chk("areset_op", 0, int'(opaque), 0);
      chk("areset_und", 0, int'(underrun), 0);
      tick(); tick();
      nRES = 1;

      // Randomized traffic on all layers
      for (int c = 0; c < 4000; c++) begin
         pix_ce = ($urandom_range(0, 2) == 0);
         line_start = ($urandom_range(0, 149) == 0);
         for (int l = 0; l < LAYERS; l++)
            if ($urandom_range(0, 11) == 0) do_load(l, RW'($urandom), PAL_W'($urandom));
         if ($urandom_range(0, 63) == 0) fine = FW'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
